fk_tap_sequencer: RTL and testbench

Parametrised successor to the filter's three-way sample selector. Holds a TAPS-deep history of N-bit filter samples (f[k], f[k-1], … f[k-TAPS+1]). On each accepted sample it shifts the history and then streams every tap, one per clock, with index and last flags. It sits between the sample source and the serial multiply-accumulate datapath, replacing the externally driven select with an internal sequencer.

---
 rtl/fk_tap_sequencer.sv | 131 +++++++++++++
 tb/tb_fk_tap_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fk_tap_sequencer.sv
// Tap sequencer: shifts the sample history on accept, then streams every tap one per clock.
// Latency 1 clk accept->first tap; ready low during the TAPS-beat sweep, offers while busy are dropped and flagged.
module fk_tap_sequencer #(
    parameter int N    = 25,
    parameter int TAPS = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N-1:0]              fk_in_i,
    input  logic                      fk_valid_i,
    input  logic                      hist_clr_i,
    input  logic                      clr_ovr_i,
    output logic                      ready_o,
    output logic [N-1:0]              tap_out_o,
    output logic [$clog2(TAPS)-1:0]   tap_idx_o,
    output logic                      tap_valid_o,
    output logic                      tap_last_o,
    output logic                      overrun_o
);

    localparam int IDXW = $clog2(TAPS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TAPS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    hist_q [TAPS];
    logic [N-1:0]    hist_d [TAPS];
    logic [N-1:0]    tap_out_q, tap_out_d;
    logic [IDXW-1:0] tap_idx_q, tap_idx_d;
    logic            tap_valid_q, tap_valid_d;
    logic            tap_last_q, tap_last_d;
    logic            overrun_q, overrun_d;
    logic            ready;

    assign ready = (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tap_out_d   = tap_out_q;
        tap_idx_d   = tap_idx_q;
        tap_valid_d = 1'b0;
        tap_last_d  = 1'b0;
        overrun_d   = overrun_q;
        for (int i = 0; i < TAPS; i++) begin
            hist_d[i] = hist_q[i];
        end

        // A new overrun event on the same edge overrides the clear below.
        if (clr_ovr_i) begin
            overrun_d = 1'b0;
        end

        if (hist_clr_i) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_d[i] = '0;
            end
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            if (fk_valid_i && !ready) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (fk_valid_i) begin
                        hist_d[0] = fk_in_i;
                        for (int i = 1; i < TAPS; i++) begin
                            hist_d[i] = hist_q[i-1];
                        end
                        state_d = ST_SWEEP;
                        cnt_d   = '0;
                    end
                end
                ST_SWEEP: begin
                    tap_out_d   = hist_q[cnt_q];
                    tap_idx_d   = cnt_q;
                    tap_valid_d = 1'b1;
                    tap_last_d  = (cnt_q == LAST_IDX);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tap_out_q   <= '0;
            tap_idx_q   <= '0;
            tap_valid_q <= 1'b0;
            tap_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tap_out_q   <= tap_out_d;
            tap_idx_q   <= tap_idx_d;
            tap_valid_q <= tap_valid_d;
            tap_last_q  <= tap_last_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign ready_o     = ready;
    assign tap_out_o   = tap_out_q;
    assign tap_idx_o   = tap_idx_q;
    assign tap_valid_o = tap_valid_q;
    assign tap_last_o  = tap_last_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_fk_tap_sequencer.sv
// Bench for fk_tap_sequencer: vector table and corner sequences on TAPS=3/N=25,
// plus randomized runs on TAPS=2 and TAPS=8 (N=12) against a queue-based history model.
module tb_fk_tap_sequencer;

    logic clk;
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [24:0] val;
        int          idx;
        logic        last;
    } beat_t;

    // ---------------- main DUT, TAPS=3, N=25 ----------------
    logic        rst, vld, hc, co;
    logic [24:0] din;
    logic        rdy, tv, tl, ovr;
    logic [24:0] tout;
    logic [1:0]  tidx;

    fk_tap_sequencer #(.N(25), .TAPS(3)) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .fk_in_i    (din),
        .fk_valid_i (vld),
        .hist_clr_i (hc),
        .clr_ovr_i  (co),
        .ready_o    (rdy),
        .tap_out_o  (tout),
        .tap_idx_o  (tidx),
        .tap_valid_o(tv),
        .tap_last_o (tl),
        .overrun_o  (ovr)
    );

    typedef struct {
        logic        rst, vld;
        logic [24:0] din;
        logic        hc, co;
        logic        rdy, tv;
        logic [24:0] tout;
        logic [1:0]  tidx;
        logic        tl, ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [24:0] d, input logic h,
                       input logic c, input logic erdy, input logic etv, input logic [24:0] eout,
                       input logic [1:0] eidx, input logic etl, input logic eovr);
        vec_t x;
        x.rst = r; x.vld = v; x.din = d; x.hc = h; x.co = c;
        x.rdy = erdy; x.tv = etv; x.tout = eout; x.tidx = eidx; x.tl = etl; x.ovr = eovr;
        vecs.push_back(x);
    endtask

    initial begin
        int          beats;
        logic [24:0] firsts[$];
        logic        all_done;

        rst = 1'b0; vld = 1'b0; hc = 1'b0; co = 1'b0; din = '0;

        //   rst v din          hc co | rdy tv out         idx last ovr
        add(1, 0, 0,           0, 0,   1, 0, 0,          0, 0, 0);
        add(0, 0, 0,           0, 0,   1, 0, 0,          0, 0, 0);
        add(0, 1, 5,           0, 0,   0, 0, 0,          0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 5,          0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 0,          1, 0, 0);
        add(0, 0, 0,           0, 0,   1, 1, 0,          2, 1, 0);
        add(0, 0, 0,           0, 0,   1, 0, 0,          2, 0, 0);
        // back-to-back 5, 7, 9 then all-ones sample
        add(1, 0, 0,           0, 0,   1, 0, 0,          0, 0, 0);
        add(0, 1, 5,           0, 0,   0, 0, 0,          0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 5,          0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 0,          1, 0, 0);
        add(0, 0, 0,           0, 0,   1, 1, 0,          2, 1, 0);
        add(0, 1, 7,           0, 0,   0, 0, 0,          2, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 7,          0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 5,          1, 0, 0);
        add(0, 0, 0,           0, 0,   1, 1, 0,          2, 1, 0);
        add(0, 1, 9,           0, 0,   0, 0, 0,          2, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 9,          0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 7,          1, 0, 0);
        add(0, 0, 0,           0, 0,   1, 1, 5,          2, 1, 0);
        add(0, 1, 25'h1FFFFFF, 0, 0,   0, 0, 5,          2, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 25'h1FFFFFF, 0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 9,          1, 0, 0);
        add(0, 0, 0,           0, 0,   1, 1, 7,          2, 1, 0);
        // overrun set, hold, clear, set-wins-over-clear
        add(1, 0, 0,           0, 0,   1, 0, 0,          0, 0, 0);
        add(0, 1, 3,           0, 0,   0, 0, 0,          0, 0, 0);
        add(0, 1, 11,          0, 0,   0, 1, 3,          0, 0, 1);
        add(0, 0, 0,           0, 0,   0, 1, 0,          1, 0, 1);
        add(0, 0, 0,           0, 0,   1, 1, 0,          2, 1, 1);
        add(0, 1, 4,           0, 0,   0, 0, 0,          2, 0, 1);
        add(0, 0, 0,           0, 0,   0, 1, 4,          0, 0, 1);
        add(0, 0, 0,           0, 0,   0, 1, 3,          1, 0, 1);
        add(0, 0, 0,           0, 0,   1, 1, 0,          2, 1, 1);
        add(0, 0, 0,           0, 1,   1, 0, 0,          2, 0, 0);
        add(0, 1, 1,           0, 0,   0, 0, 0,          2, 0, 0);
        add(0, 1, 2,           0, 1,   0, 1, 1,          0, 0, 1);
        add(0, 0, 0,           0, 0,   0, 1, 4,          1, 0, 1);
        add(0, 0, 0,           0, 0,   1, 1, 3,          2, 1, 1);
        add(0, 0, 0,           0, 1,   1, 0, 3,          2, 0, 0);
        // hist_clr mid-sweep truncates, next push sees cleared history
        add(0, 1, 6,           0, 0,   0, 0, 3,          2, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 6,          0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 1,          1, 0, 0);
        add(0, 0, 0,           1, 0,   1, 0, 1,          1, 0, 0);
        add(0, 1, 8,           0, 0,   0, 0, 1,          1, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 8,          0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 0,          1, 0, 0);
        add(0, 0, 0,           0, 0,   1, 1, 0,          2, 1, 0);
        // hist_clr beats fk_valid in idle and in sweep, no overrun
        add(0, 1, 13,          1, 0,   1, 0, 0,          2, 0, 0);
        add(0, 1, 3,           0, 0,   0, 0, 0,          2, 0, 0);
        add(0, 1, 7,           1, 0,   1, 0, 0,          2, 0, 0);
        add(0, 1, 2,           0, 0,   0, 0, 0,          2, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 2,          0, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 0,          1, 0, 0);
        add(0, 0, 0,           0, 0,   1, 1, 0,          2, 1, 0);
        // reset mid-sweep
        add(0, 1, 5,           0, 0,   0, 0, 0,          2, 0, 0);
        add(0, 0, 0,           0, 0,   0, 1, 5,          0, 0, 0);
        add(1, 0, 0,           0, 0,   1, 0, 0,          0, 0, 0);
        add(0, 0, 0,           0, 0,   1, 0, 0,          0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; vld = vecs[i].vld; din = vecs[i].din;
            hc  = vecs[i].hc;  co  = vecs[i].co;
            @(negedge clk);
            chk($sformatf("row%0d_ready", i), 64'(rdy),  64'(vecs[i].rdy));
            chk($sformatf("row%0d_valid", i), 64'(tv),   64'(vecs[i].tv));
            chk($sformatf("row%0d_out", i),   64'(tout), 64'(vecs[i].tout));
            chk($sformatf("row%0d_idx", i),   64'(tidx), 64'(vecs[i].tidx));
            chk($sformatf("row%0d_last", i),  64'(tl),   64'(vecs[i].tl));
            chk($sformatf("row%0d_ovr", i),   64'(ovr),  64'(vecs[i].ovr));
        end

        // 10 idle cycles after reset: quiet outputs
        rst = 1'b1; vld = 1'b0; hc = 1'b0; co = 1'b0; din = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_valid", c), 64'(tv), 64'd0);
            chk($sformatf("idle%0d_ready", c), 64'(rdy), 64'd1);
        end

        // fk_valid held high: one accept per TAPS+1 clocks, overrun sets
        beats = 0;
        for (int c = 0; c < 12; c++) begin
            vld = (c < 8);
            din = 25'(100 + c);
            @(negedge clk);
            if (tv) begin
                beats++;
                if (tidx == 2'd0) firsts.push_back(tout);
            end
        end
        vld = 1'b0;
        chk("held_beats", 64'(beats), 64'd6);
        chk("held_ovr", 64'(ovr), 64'd1);
        chk("held_sweeps", 64'(firsts.size()), 64'd2);
        if (firsts.size() == 2) begin
            chk("held_first0", 64'(firsts[0]), 64'd100);
            chk("held_first1", 64'(firsts[1]), 64'd104);
        end

        all_done = 1'b0;
        for (int c = 0; c < 5000 && !all_done; c++) begin
            @(negedge clk);
            all_done = g_rand[0].done && g_rand[1].done;
        end
        n_chk++;
        if (!all_done) begin
            n_fail++;
            $display("FAIL rand_timeout: random runs did not complete within budget");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // ---------------- randomized parameter sweep ----------------
    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int T  = (g == 0) ? 2 : 8;
        localparam int IW = $clog2(T);

        logic          r_rst, r_vld, r_hc, r_co;
        logic [11:0]   r_din;
        logic          r_rdy, r_tv, r_tl, r_ovr;
        logic [11:0]   r_tout;
        logic [IW-1:0] r_tidx;
        logic          done = 1'b0;

        fk_tap_sequencer #(.N(12), .TAPS(T)) u_dut (
            .clk_i      (clk),
            .rst_i      (r_rst),
            .fk_in_i    (r_din),
            .fk_valid_i (r_vld),
            .hist_clr_i (r_hc),
            .clr_ovr_i  (r_co),
            .ready_o    (r_rdy),
            .tap_out_o  (r_tout),
            .tap_idx_o  (r_tidx),
            .tap_valid_o(r_tv),
            .tap_last_o (r_tl),
            .overrun_o  (r_ovr)
        );

        initial begin
            logic [11:0] hist[$];
            beat_t       pend[$];
            beat_t       b;
            logic [11:0] e_out;
            int          e_idx;
            logic        e_tv, e_tl, e_ovr, busy;

            r_rst = 1'b1; r_vld = 1'b0; r_hc = 1'b0; r_co = 1'b0; r_din = '0;
            @(negedge clk);
            r_rst = 1'b0;
            for (int k = 0; k < T; k++) hist.push_back(12'd0);
            e_out = '0; e_idx = 0; e_tv = 1'b0; e_tl = 1'b0; e_ovr = 1'b0;

            for (int c = 0; c < 600; c++) begin
                chk($sformatf("T%0d_c%0d_ready", T, c), 64'(r_rdy),  64'(pend.size() == 0));
                chk($sformatf("T%0d_c%0d_valid", T, c), 64'(r_tv),   64'(e_tv));
                chk($sformatf("T%0d_c%0d_last", T, c),  64'(r_tl),   64'(e_tl));
                chk($sformatf("T%0d_c%0d_out", T, c),   64'(r_tout), 64'(e_out));
                chk($sformatf("T%0d_c%0d_idx", T, c),   64'(r_tidx), 64'(e_idx));
                chk($sformatf("T%0d_c%0d_ovr", T, c),   64'(r_ovr),  64'(e_ovr));

                r_vld = ($urandom_range(0, 2) != 0);
                r_hc  = ($urandom_range(0, 29) == 0);
                r_co  = ($urandom_range(0, 9) == 0);
                r_din = 12'($urandom);

                busy = (pend.size() != 0);
                if (r_vld && busy && !r_hc) e_ovr = 1'b1;
                else if (r_co)              e_ovr = 1'b0;

                if (r_hc) begin
                    e_tv = 1'b0; e_tl = 1'b0;
                    pend.delete();
                    for (int k = 0; k < T; k++) hist[k] = 12'd0;
                end else if (busy) begin
                    b = pend.pop_front();
                    e_tv = 1'b1; e_out = 12'(b.val); e_idx = b.idx; e_tl = b.last;
                end else begin
                    e_tv = 1'b0; e_tl = 1'b0;
                    if (r_vld) begin
                        hist.push_front(r_din);
                        void'(hist.pop_back());
                        for (int k = 0; k < T; k++) begin
                            b.val = 25'(hist[k]); b.idx = k; b.last = (k == T - 1);
                            pend.push_back(b);
                        end
                    end
                end
                @(negedge clk);
            end
            r_vld = 1'b0; r_hc = 1'b0; r_co = 1'b0;
            done = 1'b1;
        end
    end

endmodule
